// File: rtl/loader_pkg.sv
// Shared constants and types for the boot-time instruction loader.
package loader_pkg;

  localparam logic [31:0] END_MARKER = 32'hFFFF_FFFF;
  localparam int          BYTE_IDX_W = 2;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/byte_fifo.sv
// Small byte FIFO with registered head; a push into a full FIFO is dropped
// unless a pop happens in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_overflow;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  assign w_full  = (r_count == FULL_COUNT);
  assign w_empty = (r_count == '0);
  // A pop on an empty FIFO is ignored, so a same-cycle push still lands.
  assign w_pop   = i_pop && !w_empty;
  assign w_push  = i_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (i_push && !w_push) r_overflow <= 1'b1;
    end
  end

  assign o_data     = r_mem[r_rd_ptr];
  assign o_valid    = !w_empty;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/inst_loader.sv
// Boot loader: packs received bytes MSB-first into instruction words until the
// all-ones end marker, then buffers later bytes for the core. INST_LOADER_CHECKSUM_EN adds a word checksum.
//
// state | meaning
// LOAD  | assembling words and writing instruction memory; core held
// RUN   | marker accepted; bytes go to the input FIFO (terminal until reset)
module inst_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int MEM_DEPTH  = 16384,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_changed,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count,
  output logic              load_overflow,
  output logic [7:0]        in_data,
  output logic              in_valid,
  input  logic              in_ready,
  output logic              in_overflow,
  output logic [31:0]       checksum
);

  localparam logic [ADDR_W:0]       MEM_LIMIT = (ADDR_W + 1)'(MEM_DEPTH);
  localparam logic [BYTE_IDX_W-1:0] LAST_IDX  = '1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [BYTE_IDX_W-1:0] r_byte_idx;
  logic [31:0]           r_shift;
  logic                  r_imem_we;
  logic [ADDR_W-1:0]     r_imem_addr;
  logic [31:0]           r_imem_wdata;
  logic [ADDR_W:0]       r_word_count;
  logic                  r_load_overflow;

  logic [31:0] w_word;
  logic        w_do_write;
  logic        w_drop;
  logic        w_fifo_push;

  always_ff @(posedge clk) begin
    if (reset) r_state <= LOAD;
    else       r_state <= w_state_nxt;
  end

  // The marker only counts when it lands exactly on a word boundary.
  always_comb begin
    w_state_nxt = r_state;
    w_word      = {r_shift[23:0], rx_data};
    w_do_write  = 1'b0;
    w_drop      = 1'b0;
    if (r_state == LOAD && rx_changed && r_byte_idx == LAST_IDX) begin
      if (w_word == END_MARKER)          w_state_nxt = RUN;
      else if (r_word_count < MEM_LIMIT) w_do_write  = 1'b1;
      else                               w_drop      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_byte_idx      <= '0;
      r_shift         <= '0;
      r_imem_we       <= 1'b0;
      r_imem_addr     <= '0;
      r_imem_wdata    <= '0;
      r_word_count    <= '0;
      r_load_overflow <= 1'b0;
    end else begin
      r_imem_we <= w_do_write;
      if (r_state == LOAD && rx_changed) begin
        r_shift    <= w_word;
        r_byte_idx <= r_byte_idx + 1'b1;
      end
      if (w_do_write) begin
        r_imem_addr  <= r_word_count[ADDR_W-1:0];
        r_imem_wdata <= w_word;
        r_word_count <= r_word_count + 1'b1;
      end
      if (w_drop) r_load_overflow <= 1'b1;
    end
  end

  assign w_fifo_push = (r_state == RUN) && rx_changed;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_byte_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_fifo_push),
    .i_data     (rx_data),
    .i_pop      (in_ready),
    .o_data     (in_data),
    .o_valid    (in_valid),
    .o_overflow (in_overflow)
  );

`ifdef INST_LOADER_CHECKSUM_EN
  logic [31:0] r_checksum;

  always_ff @(posedge clk) begin
    if (reset)          r_checksum <= '0;
    else if (r_imem_we) r_checksum <= r_checksum + r_imem_wdata;
  end

  assign checksum = r_checksum;
`else
  assign checksum = 32'h0;
`endif

  assign imem_we       = r_imem_we;
  assign imem_addr     = r_imem_addr;
  assign imem_wdata    = r_imem_wdata;
  assign load_done     = (r_state == RUN);
  assign word_count    = r_word_count;
  assign load_overflow = r_load_overflow;

endmodule
